// File: rtl/board_input_ctrl_pkg.sv
// Shared types and constants for the board input controller: step FSM states,
// display-select encodings and the index of each raw input in the debounce bank.
`timescale 1ns/1ps
package board_input_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HIGH     = 2'd1,
        ST_WAIT_REL = 2'd2
    } step_state_t;

    // {chreg1, chreg2, chPC}
    localparam logic [2:0] SEL_REG1 = 3'b100;
    localparam logic [2:0] SEL_REG2 = 3'b010;
    localparam logic [2:0] SEL_PC   = 3'b001;
    localparam logic [2:0] SEL_NONE = 3'b000;

    localparam int NUM_INPUTS = 5;
    localparam int IDX_STEP   = 0;
    localparam int IDX_AUTO   = 1;
    localparam int IDX_REG1   = 2;
    localparam int IDX_REG2   = 3;
    localparam int IDX_PC     = 4;

    // PC beats reg2 beats reg1 when edges coincide; SEL_NONE means no edge.
    function automatic logic [2:0] sel_priority(input logic rise_reg1,
                                                input logic rise_reg2,
                                                input logic rise_pc);
        logic [2:0] result;
        result = SEL_NONE;
        if (rise_pc) begin
            result = SEL_PC;
        end else if (rise_reg2) begin
            result = SEL_REG2;
        end else if (rise_reg1) begin
            result = SEL_REG1;
        end
        return result;
    endfunction

endpackage

// File: rtl/board_input_ctrl_debounce.sv
// Two-flop synchroniser followed by a counting debouncer: the level follows the
// synchronised input only after it has disagreed for DEB_CYCLES consecutive cycles.
`timescale 1ns/1ps
module board_input_ctrl_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic mainClk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic level_next
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync_reg;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic          level_reg;
    logic          level_next_c;

    always_comb begin
        cnt_next     = '0;
        level_next_c = level_reg;
        if (sync_reg[1] != level_reg) begin
            if (cnt_reg == CNT_LAST) begin
                level_next_c = sync_reg[1];
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge mainClk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg  <= 2'b00;
            cnt_reg   <= '0;
            level_reg <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[0], raw};
            cnt_reg   <= cnt_next;
            level_reg <= level_next_c;
        end
    end

    // level_next lets the consumer react on the very edge the level changes.
    assign level      = level_reg;
    assign level_next = level_next_c;

endmodule

// File: rtl/board_input_ctrl.sv
// Board input controller: debounces the panel inputs, generates the CPU clock in
// single-step or free-running mode, tracks display selection and counts clk edges.
`timescale 1ns/1ps
module board_input_ctrl
    import board_input_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = 16,
    parameter int STEP_HIGH  = 4,
    parameter int AUTO_DIV   = 8
) (
    input  logic       mainClk,
    input  logic       reset,
    input  logic       btn_step,
    input  logic       sw_auto,
    input  logic       btn_reg1,
    input  logic       btn_reg2,
    input  logic       btn_pc,
    output logic       clk,
    output logic       chreg1,
    output logic       chreg2,
    output logic       chPC,
    output logic [7:0] step_cnt
);

    localparam int HW = (STEP_HIGH > 1) ? $clog2(STEP_HIGH) : 1;
    localparam int DW = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
    localparam logic [HW-1:0] HIGH_LAST = HW'(STEP_HIGH - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(AUTO_DIV - 1);

    // Assertion is immediate; release takes effect one edge later.
    logic rst_n_int;

    always_ff @(posedge mainClk or negedge reset) begin
        if (!reset) begin
            rst_n_int <= 1'b0;
        end else begin
            rst_n_int <= 1'b1;
        end
    end

    logic [NUM_INPUTS-1:0] raw_vec;
    logic [NUM_INPUTS-1:0] deb_level;
    logic [NUM_INPUTS-1:0] deb_next;
    logic [NUM_INPUTS-1:0] deb_rise;

    assign raw_vec  = {btn_pc, btn_reg2, btn_reg1, sw_auto, btn_step};
    assign deb_rise = deb_next & ~deb_level;

    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_deb
        board_input_ctrl_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .mainClk   (mainClk),
            .rst_n     (rst_n_int),
            .raw       (raw_vec[gi]),
            .level     (deb_level[gi]),
            .level_next(deb_next[gi])
        );
    end

    logic        auto_level;
    logic        auto_next;
    logic        step_level;
    logic        step_rise;

    assign auto_level = deb_level[IDX_AUTO];
    assign auto_next  = deb_next[IDX_AUTO];
    assign step_level = deb_level[IDX_STEP];
    assign step_rise  = deb_rise[IDX_STEP];

    step_state_t   state_reg, state_next;
    logic [HW-1:0] hcnt_reg, hcnt_next;
    logic [DW-1:0] div_reg, div_next;
    logic          clk_reg, clk_next;
    logic [7:0]    step_cnt_reg;
    logic [2:0]    sel_reg;
    logic [2:0]    sel_hit;

    always_comb begin
        state_next = state_reg;
        hcnt_next  = hcnt_reg;
        div_next   = div_reg;
        clk_next   = clk_reg;
        if (auto_next) begin
            state_next = ST_IDLE;
            hcnt_next  = '0;
            // Entering auto truncates any step pulse and restarts the divider.
            if (!auto_level) begin
                div_next = '0;
                clk_next = 1'b0;
            end else if (div_reg == DIV_LAST) begin
                div_next = '0;
                clk_next = ~clk_reg;
            end else begin
                div_next = div_reg + 1'b1;
            end
        end else if (auto_level) begin
            // Leaving auto abandons the half-period in progress.
            state_next = ST_IDLE;
            hcnt_next  = '0;
            div_next   = '0;
            clk_next   = 1'b0;
        end else begin
            div_next = '0;
            case (state_reg)
                ST_IDLE: begin
                    if (step_rise) begin
                        state_next = ST_HIGH;
                        hcnt_next  = '0;
                        clk_next   = 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (hcnt_reg == HIGH_LAST) begin
                        state_next = ST_WAIT_REL;
                        hcnt_next  = '0;
                        clk_next   = 1'b0;
                    end else begin
                        hcnt_next = hcnt_reg + 1'b1;
                    end
                end
                ST_WAIT_REL: begin
                    if (!step_level) begin
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    clk_next   = 1'b0;
                end
            endcase
        end
    end

    assign sel_hit = sel_priority(deb_rise[IDX_REG1], deb_rise[IDX_REG2], deb_rise[IDX_PC]);

    always_ff @(posedge mainClk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_reg    <= ST_IDLE;
            hcnt_reg     <= '0;
            div_reg      <= '0;
            clk_reg      <= 1'b0;
            step_cnt_reg <= 8'd0;
            sel_reg      <= SEL_PC;
        end else begin
            state_reg <= state_next;
            hcnt_reg  <= hcnt_next;
            div_reg   <= div_next;
            clk_reg   <= clk_next;
            if (clk_next && !clk_reg) begin
                step_cnt_reg <= step_cnt_reg + 8'd1;
            end
            if (sel_hit != SEL_NONE) begin
                sel_reg <= sel_hit;
            end
        end
    end

    assign clk                  = clk_reg;
    assign step_cnt             = step_cnt_reg;
    assign {chreg1, chreg2, chPC} = sel_reg;

endmodule

// File: doc/board_input_ctrl.md
BOARD_INPUT_CTRL -- requirements
Module: board_input_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 16: number of mainClk cycles a raw input must hold a new level before it is accepted.
REQ-002 Parameter STEP_HIGH, default 4: width of one single-step clk pulse, in mainClk cycles.
REQ-003 Parameter AUTO_DIV, default 8: in auto mode, clk toggles every AUTO_DIV mainClk cycles.
REQ-004 mainClk  in  1: the only clock; every flop is rising-edge mainClk.
REQ-005 reset  in  1: asynchronous, active-low reset.
REQ-006 btn_step  in  1: raw, unsynchronised single-step push-button.
REQ-007 sw_auto  in  1: raw switch; 1 = free-running clk, 0 = single-step clk.
REQ-008 btn_reg1, btn_reg2, btn_pc  in  1 each: raw display-select push-buttons.
REQ-009 clk  out  1: CPU clock, registered.
REQ-010 chreg1, chreg2, chPC  out  1 each: debounced display-select levels; at most one is high.
REQ-011 step_cnt  out  8: count of clk rising edges issued since reset.

Function
REQ-012 Every raw input passes a 2-flop synchroniser, then an independent debouncer.
REQ-013 Debouncer: the output changes only after the synchronised input differs from it for DEB_CYCLES consecutive cycles; any bounce restarts the count from 0.
REQ-014 Debounced latency = 2 + DEB_CYCLES cycles from a stable raw edge.
REQ-015 Step FSM states: IDLE, HIGH, WAIT_REL.
REQ-016 IDLE -> HIGH on a debounced btn_step rising edge while debounced sw_auto = 0; clk goes 1 on that same cycle.
REQ-017 HIGH lasts exactly STEP_HIGH cycles, then clk = 0 and the FSM goes to WAIT_REL.
REQ-018 WAIT_REL -> IDLE when debounced btn_step = 0, so a held button produces exactly one pulse.
REQ-019 Auto mode (debounced sw_auto = 1): a divider counter toggles clk every AUTO_DIV cycles, and the step FSM is forced to IDLE.
REQ-020 Auto -> step transition: the divider clears, clk is driven 0 at once, and any half-period in progress is abandoned.
REQ-021 Step -> auto transition during HIGH: the pulse is truncated, clk = 0 and the divider starts from 0.
REQ-022 Select rising edges (debounced): btn_reg1 -> {chreg1,chreg2,chPC} = 100; btn_reg2 -> 010; btn_pc -> 001.
REQ-023 Select outputs hold their value until the next select edge.
REQ-024 Simultaneous select edges in one cycle: priority is btn_pc > btn_reg2 > btn_reg1.
REQ-025 step_cnt increments on each 0->1 transition of clk, in either mode, and wraps 255 -> 0.
REQ-026 Debounced btn_step edges arriving during HIGH or WAIT_REL are ignored.

Reset
REQ-027 reset = 0 asynchronously clears: clk = 0, step_cnt = 0, {chreg1,chreg2,chPC} = 001 (PC shown), FSM = IDLE, divider = 0.
REQ-028 reset = 0 also clears synchronisers and debouncer counters, and sets every debounced level to 0.
REQ-029 Reset asserted mid-pulse forces clk = 0 on the same cycle, with no glitch after release.
REQ-030 Release of reset is synchronised internally; the first functional cycle is the second mainClk edge after release.

Structure
REQ-031 A shared package holds the step FSM state enum and the select encoding constants (SEL_REG1, SEL_REG2, SEL_PC).
REQ-032 Sub-module debounce (sync + counter, parameter DEB_CYCLES) is instantiated 5 times.
REQ-033 Expected size is roughly 150-250 RTL lines.

Verification
REQ-034 Reset release with all inputs 0 -> clk = 0, step_cnt = 0, chPC = 1, chreg1 = chreg2 = 0.
REQ-035 btn_step held high for 100 cycles -> exactly one clk pulse, 4 cycles wide, beginning 18 cycles after the raw edge; step_cnt = 1.
REQ-036 btn_step bouncing at a 5-cycle period for 60 cycles, then stable high -> exactly one pulse, and no pulse during the bounce.
REQ-037 sw_auto = 1 for 200 cycles -> clk period 16 cycles after debounce; step_cnt = 11 or 12; sw_auto then 0 mid-high -> clk = 0 within 19 cycles.
REQ-038 btn_reg1 and btn_pc pressed on the same cycle -> chPC = 1; then btn_reg2 alone -> chreg2 = 1, other selects 0.
REQ-039 reset pulsed low during HIGH, then 256 step presses -> clk cleared immediately, step_cnt wraps to 0.
